tlv5618_dac_sched: RTL and testbench



---
 rtl/tlv5618_pkg.sv | 25 ++
 rtl/tlv5618_rr_arb2.sv | 14 +
 rtl/tlv5618_dac_sched.sv | 150 +++++++++++++++
 tb/tb_tlv5618_dac_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tlv5618_pkg.sv
// Shared types and helpers for the TLV5618 DAC frame scheduler.
// The TLV5618_SIMUL_UPDATE_EN build uses ST_PEND_A; other builds never reach it.
package tlv5618_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PEND_A = 3'd4
  } state_t;

  // R1/R0 field values of the TLV5618 control nibble
  localparam logic [1:0] CMD_WR_A   = 2'b10;
  localparam logic [1:0] CMD_WR_B   = 2'b00;
  localparam logic [1:0] CMD_WR_BUF = 2'b01;

  function automatic logic [15:0] build_word(input logic [1:0]  cmd,
                                             input logic        spd,
                                             input logic        pwr,
                                             input logic [11:0] code);
    return {cmd[1], spd, pwr, cmd[0], code};
  endfunction

endpackage

// File: rtl/tlv5618_rr_arb2.sv
// Two-request round-robin arbiter: a lone request always wins; on contention
// the channel that did not win last time (last_gnt: 0=A, 1=B) is granted.
module tlv5618_rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_gnt,
  output logic gnt_a,
  output logic gnt_b
);

  assign gnt_a = req_a && (!req_b || last_gnt);
  assign gnt_b = req_b && (!req_a || !last_gnt);

endmodule

// File: rtl/tlv5618_dac_sched.sv
// Round-robin request scheduler and frame sequencer for the TLV5618 serializer.
// Optional build macro TLV5618_SIMUL_UPDATE_EN: simultaneous A/B requests update both DAC outputs together.
//
// state     | meaning
// ----------|---------------------------------------------------------
// ST_IDLE   | ready offered to the arbitrated channel, waiting for a request
// ST_LOAD   | ser_start pulse, timeout counter armed
// ST_WAIT   | frame in flight, waiting for ser_done or timeout
// ST_GAP    | serializer held idle for GAP_CYC cycles
// ST_PEND_A | (simul-update build) load the held A word after the buffer frame
module tlv5618_dac_sched
  import tlv5618_pkg::*;
#(
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [11:0] a_code,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [11:0] b_code,
  input  logic        fast_mode,
  input  logic        pwr_down,
  output logic        ser_start,
  output logic [15:0] ser_word,
  input  logic        ser_done,
  output logic        busy,
  output logic        grant_ch,
  output logic        timeout_err
);

  localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYC - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        gnt_a, gnt_b;
  logic        in_idle, a_fire, b_fire;

  tlv5618_rr_arb2 u_arb (
    .req_a    (a_valid),
    .req_b    (b_valid),
    .last_gnt (grant_ch),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b)
  );

  // reset gates the readies so a held request is never acknowledged during reset
  assign in_idle = sys_rst_n && (state == ST_IDLE);

`ifdef TLV5618_SIMUL_UPDATE_EN
  logic        both_req;
  logic        pend_a;
  logic [11:0] pend_code;
  logic        pend_spd, pend_pwr;

  assign both_req = a_valid && b_valid;
  assign a_ready  = in_idle && (gnt_a || both_req);
  assign b_ready  = in_idle && (gnt_b || both_req);
`else
  assign a_ready  = in_idle && gnt_a;
  assign b_ready  = in_idle && gnt_b;
`endif

  assign a_fire    = a_valid && a_ready;
  assign b_fire    = b_valid && b_ready;
  assign ser_start = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ser_word    <= '0;
      grant_ch    <= 1'b1;
      timeout_err <= 1'b0;
`ifdef TLV5618_SIMUL_UPDATE_EN
      pend_a      <= 1'b0;
      pend_code   <= '0;
      pend_spd    <= 1'b0;
      pend_pwr    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef TLV5618_SIMUL_UPDATE_EN
          if (a_fire && b_fire) begin
            ser_word  <= build_word(CMD_WR_BUF, fast_mode, pwr_down, b_code);
            grant_ch  <= 1'b1;
            pend_a    <= 1'b1;
            pend_code <= a_code;
            pend_spd  <= fast_mode;
            pend_pwr  <= pwr_down;
            state     <= ST_LOAD;
          end else
`endif
          if (a_fire) begin
            ser_word <= build_word(CMD_WR_A, fast_mode, pwr_down, a_code);
            grant_ch <= 1'b0;
            state    <= ST_LOAD;
          end else if (b_fire) begin
            ser_word <= build_word(CMD_WR_B, fast_mode, pwr_down, b_code);
            grant_ch <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt   <= TO_LOAD;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ser_done) begin
            cnt   <= GAP_LOAD;
            state <= ST_GAP;
          end else if (cnt == '0) begin
            timeout_err <= 1'b1;
            cnt         <= GAP_LOAD;
            state       <= ST_GAP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
`ifdef TLV5618_SIMUL_UPDATE_EN
            state <= pend_a ? ST_PEND_A : ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
`ifdef TLV5618_SIMUL_UPDATE_EN
        ST_PEND_A: begin
          ser_word <= build_word(CMD_WR_A, pend_spd, pend_pwr, pend_code);
          grant_ch <= 1'b0;
          pend_a   <= 1'b0;
          state    <= ST_LOAD;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlv5618_dac_sched.sv
// Directed bench for tlv5618_dac_sched; honours TLV5618_SIMUL_UPDATE_EN when defined.
module tb_tlv5618_dac_sched;

  localparam int GAP = 4;
  localparam int TO  = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [11:0] a_code = '0, b_code = '0;
  logic        fast_mode = 1'b0, pwr_down = 1'b0, ser_done = 1'b0;
  logic        a_ready, b_ready, ser_start, busy, grant_ch, timeout_err;
  logic [15:0] ser_word;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cyc = 0;
  int n;

  tlv5618_dac_sched #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_code(a_code),
    .b_valid(b_valid), .b_ready(b_ready), .b_code(b_code),
    .fast_mode(fast_mode), .pwr_down(pwr_down),
    .ser_start(ser_start), .ser_word(ser_word), .ser_done(ser_done),
    .busy(busy), .grant_ch(grant_ch), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, output int waited);
    waited = 0;
    while (ser_start !== 1'b1 && waited < 40) begin
      @(negedge sys_clk);
      waited++;
    end
    chk(tag, {15'd0, ser_start}, 16'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 40) begin
      @(negedge sys_clk);
      k++;
    end
    chk(tag, {15'd0, busy}, 16'd0);
  endtask

  task automatic pulse_done();
    @(negedge sys_clk);
    ser_done = 1'b1;
    done_cyc = cyc;
    @(negedge sys_clk);
    ser_done = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h0222; exp_seq[1] = 16'h8111;
    exp_seq[2] = 16'h0222; exp_seq[3] = 16'h8111;

    // reset values
    repeat (2) @(negedge sys_clk);
    chk("rst_word", ser_word, 16'h0000);
    chk("rst_grant", {15'd0, grant_ch}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_start", {15'd0, ser_start}, 16'd0);
    chk("rst_err", {15'd0, timeout_err}, 16'd0);
    chk("rst_ready", {14'd0, a_ready, b_ready}, 16'd0);
    sys_rst_n = 1'b1;

    // A only: 0x3A5, SPD=1
    @(negedge sys_clk);
    a_valid = 1'b1; a_code = 12'h3A5; fast_mode = 1'b1; pwr_down = 1'b0;
    #1 chk("a_only_ready", {14'd0, a_ready, b_ready}, 16'b10);
    @(negedge sys_clk);
    a_valid = 1'b0;
    chk("a_only_start", {15'd0, ser_start}, 16'd1);
    chk("a_only_word", ser_word, 16'hC3A5);
    chk("a_only_grant", {15'd0, grant_ch}, 16'd0);
    chk("a_only_ready_drop", {15'd0, a_ready}, 16'd0);
    @(negedge sys_clk);
    chk("a_only_start_1cyc", {15'd0, ser_start}, 16'd0);
    @(negedge sys_clk);
    ser_done = 1'b1;
    @(negedge sys_clk);
    ser_done = 1'b0;
    repeat (GAP - 1) @(negedge sys_clk);
    chk("gap_busy_last", {15'd0, busy}, 16'd1);
    @(negedge sys_clk);
    chk("gap_busy_drop", {15'd0, busy}, 16'd0);

    // stray ser_done in IDLE
    ser_done = 1'b1;
    @(negedge sys_clk);
    ser_done = 1'b0;
    chk("stray_done_busy", {15'd0, busy}, 16'd0);

    // B only: 0x123; SPD/PWR changed after grant must not leak in
    b_valid = 1'b1; b_code = 12'h123; fast_mode = 1'b0; pwr_down = 1'b0;
    #1 chk("b_only_ready", {14'd0, a_ready, b_ready}, 16'b01);
    @(negedge sys_clk);
    b_valid = 1'b0; fast_mode = 1'b1; pwr_down = 1'b1;
    chk("b_only_start", {15'd0, ser_start}, 16'd1);
    chk("b_only_word", ser_word, 16'h0123);
    chk("b_only_grant", {15'd0, grant_ch}, 16'd1);
    @(negedge sys_clk);
    chk("b_only_word_hold", ser_word, 16'h0123);
    a_valid = 1'b1; a_code = 12'hFFF;
    @(negedge sys_clk);
    a_valid = 1'b0; fast_mode = 1'b0; pwr_down = 1'b0;
    pulse_done();
    wait_idle("b_only_idle");
    chk("dropped_valid_word", ser_word, 16'h0123);

    // A with PWR=1
    a_valid = 1'b1; a_code = 12'h5A0; pwr_down = 1'b1;
    @(negedge sys_clk);
    a_valid = 1'b0; pwr_down = 1'b0;
    chk("a_pwr_word", ser_word, 16'hA5A0);
    pulse_done();
    wait_idle("a_pwr_idle");

`ifndef TLV5618_SIMUL_UPDATE_EN
    // both held valid; last grant was A so B goes first
    a_valid = 1'b1; b_valid = 1'b1; a_code = 12'h111; b_code = 12'h222;
    for (int i = 0; i < 4; i++) begin
      wait_start("rr_start", n);
      if (i == 3) begin a_valid = 1'b0; b_valid = 1'b0; end
      chk("rr_word", ser_word, exp_seq[i]);
      if (i > 0) chk("rr_spacing", 16'(cyc - done_cyc), 16'(GAP + 2));
      @(negedge sys_clk);
      pulse_done();
    end
    wait_idle("rr_idle");
`endif

    // serializer never answers
    a_valid = 1'b1; a_code = 12'h00F;
    #1 chk("to_ready", {15'd0, a_ready}, 16'd1);
    @(negedge sys_clk);
    a_valid = 1'b0;
    chk("to_start", {15'd0, ser_start}, 16'd1);
    repeat (TO) @(negedge sys_clk);
    chk("to_err_before", {15'd0, timeout_err}, 16'd0);
    @(negedge sys_clk);
    chk("to_err_set", {15'd0, timeout_err}, 16'd1);
    wait_idle("to_idle");
    b_valid = 1'b1; b_code = 12'h0AB; fast_mode = 1'b1; pwr_down = 1'b1;
    #1 chk("to_recover_ready", {15'd0, b_ready}, 16'd1);
    @(negedge sys_clk);
    b_valid = 1'b0; fast_mode = 1'b0; pwr_down = 1'b0;
    chk("to_recover_word", ser_word, 16'h60AB);
    pulse_done();
    wait_idle("to_recover_idle");
    chk("to_err_sticky", {15'd0, timeout_err}, 16'd1);

    // reset while in WAIT
    a_valid = 1'b1; a_code = 12'h777;
    @(negedge sys_clk);
    a_valid = 1'b0;
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
`ifdef TLV5618_SIMUL_UPDATE_EN
    a_code = 12'h456; b_code = 12'h789;
`else
    a_code = 12'h111; b_code = 12'h222;
`endif
    #1;
    chk("mid_rst_word", ser_word, 16'h0000);
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk("mid_rst_grant", {15'd0, grant_ch}, 16'd1);
    chk("mid_rst_err", {15'd0, timeout_err}, 16'd0);
    chk("mid_rst_ready", {13'd0, a_ready, b_ready, ser_start}, 16'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
`ifdef TLV5618_SIMUL_UPDATE_EN
    #1 chk("simul_ready", {14'd0, a_ready, b_ready}, 16'b11);
    @(negedge sys_clk);
    a_valid = 1'b0; b_valid = 1'b0;
    chk("simul_buf_word", ser_word, 16'h1789);
    pulse_done();
    wait_start("simul_a_start", n);
    chk("simul_a_word", ser_word, 16'h8456);
    chk("simul_grant", {15'd0, grant_ch}, 16'd0);
    pulse_done();
    wait_idle("simul_idle");
    chk("simul_grant_end", {15'd0, grant_ch}, 16'd0);
`else
    #1 chk("post_rst_ready", {14'd0, a_ready, b_ready}, 16'b10);
    @(negedge sys_clk);
    a_valid = 1'b0; b_valid = 1'b0;
    chk("post_rst_word", ser_word, 16'h8111);
    chk("post_rst_grant", {15'd0, grant_ch}, 16'd0);
    pulse_done();
    wait_idle("post_rst_idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
